// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger engine: FSM state encoding and default
// sizing constants used by the top level and the condition evaluator.
package trigger_pkg;

  // Default sizing for the capture path.
  localparam int DEF_CHANNELS = 8;
  localparam int DEF_CNT_W    = 8;

  // FSM encoding, kept as plain constants so older tools can use them too.
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE      = 2'd0;
  localparam logic [STATE_W-1:0] ST_PRIME     = 2'd1;
  localparam logic [STATE_W-1:0] ST_ARMED     = 2'd2;
  localparam logic [STATE_W-1:0] ST_TRIGGERED = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = ST_IDLE,
    PRIME     = ST_PRIME,
    ARMED     = ST_ARMED,
    TRIGGERED = ST_TRIGGERED
  } state_e;

endpackage

// File: rtl/trigger_cond_eval.sv
// Combinational per-sample trigger condition. Each channel combines its
// enabled edge and level terms with AND; channels with no enabled term are
// left out of the AND/OR reduction. With no term enabled anywhere the
// condition is always true, so the first evaluated sample matches.
module trigger_cond_eval
  import trigger_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic [CHANNELS-1:0] prev_i,
  input  logic [CHANNELS-1:0] new_i,
  input  logic [CHANNELS-1:0] edge_mask_i,
  input  logic [CHANNELS-1:0] edge_rise_i,
  input  logic [CHANNELS-1:0] level_mask_i,
  input  logic [CHANNELS-1:0] level_val_i,
  input  logic                mode_or_i,
  output logic                match_o
);

  logic [CHANNELS-1:0] chan_hit;
  logic [CHANNELS-1:0] chan_en;
  logic                none_en;
  logic                all_hit;
  logic                any_hit;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic rise;
      logic fall;
      logic edge_hit;
      logic lvl_hit;
      assign rise     = ~prev_i[gi] & new_i[gi];
      assign fall     = prev_i[gi] & ~new_i[gi];
      assign edge_hit = edge_rise_i[gi] ? rise : fall;
      assign lvl_hit  = (new_i[gi] == level_val_i[gi]);
      // A disabled term is treated as satisfied so only enabled terms count.
      assign chan_hit[gi] = (~edge_mask_i[gi] | edge_hit) & (~level_mask_i[gi] | lvl_hit);
      assign chan_en[gi]  = edge_mask_i[gi] | level_mask_i[gi];
    end
  endgenerate

  assign none_en = ~(|chan_en);
  assign all_hit = &(chan_hit | ~chan_en);
  assign any_hit = |(chan_hit & chan_en);
  assign match_o = none_en | (mode_or_i ? any_hit : all_hit);

endmodule

// File: rtl/trigger_engine.sv
// Multi-channel trigger engine for the logic analyzer capture path.
// Samples pass through a synchroniser and a sample register with a valid
// strobe; an armed acquisition evaluates edge/level conditions per sample
// and fires a trigger pulse aligned with the data_valid of the sample that
// satisfied it.
// Build option: define TRIGGER_ENGINE_COUNT_EN to require match_count
// matches before firing; otherwise the first match fires and match_count
// is ignored.
module trigger_engine
  import trigger_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                clk_PLL,
  input  logic                reset_n,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] data_in,
  input  logic                arm,
  input  logic                abort,
  input  logic [CHANNELS-1:0] edge_mask,
  input  logic [CHANNELS-1:0] edge_rise,
  input  logic [CHANNELS-1:0] level_mask,
  input  logic [CHANNELS-1:0] level_val,
  input  logic                mode_or,
  input  logic [CNT_W-1:0]    match_count,
  output logic [CHANNELS-1:0] data_out,
  output logic                data_valid,
  output logic                armed,
  output logic                trig_pulse,
  output logic                triggered
);

  logic [CHANNELS-1:0] sync_out;

  // Synchroniser runs every cycle so that sample_en only decimates the
  // already-synchronous stream and latency stays SYNC_STAGES + 1 cycles.
  genvar gi;
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_out = data_in;
    end else begin : g_sync
      logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        logic [CHANNELS-1:0] stage_d;
        if (gi == 0) begin : g_first
          assign stage_d = data_in;
        end else begin : g_next
          assign stage_d = sync_q[gi-1];
        end
        // One synchroniser flop stage.
        always_ff @(posedge clk_PLL or negedge reset_n) begin
          if (!reset_n) begin
            sync_q[gi] <= '0;
          end else begin
            sync_q[gi] <= stage_d;
          end
        end
      end
      assign sync_out = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Latched acquisition configuration.
  logic [CHANNELS-1:0] edge_mask_q;
  logic [CHANNELS-1:0] edge_rise_q;
  logic [CHANNELS-1:0] level_mask_q;
  logic [CHANNELS-1:0] level_val_q;
  logic                mode_or_q;

  // Sample path and FSM state.
  logic [CHANNELS-1:0] data_q;
  logic                valid_q;
  logic                trig_q;
  logic                trig_d;
  state_e              state_q;
  state_e              state_d;

  logic cfg_load;
  logic match;
  logic eval_en;
  logic eval_hit;
  logic count_done;

  // abort wins over arm, so a simultaneous pair never loads a new config.
  assign cfg_load = arm & ~abort;
  assign eval_en  = sample_en & ~arm & ~abort & (state_q == ARMED);
  assign eval_hit = eval_en & match;

  // data_q still holds the previous sample while the new one is presented,
  // so it doubles as the edge-detect history.
  trigger_cond_eval #(
    .CHANNELS (CHANNELS)
  ) u_cond_eval (
    .prev_i       (data_q),
    .new_i        (sync_out),
    .edge_mask_i  (edge_mask_q),
    .edge_rise_i  (edge_rise_q),
    .level_mask_i (level_mask_q),
    .level_val_i  (level_val_q),
    .mode_or_i    (mode_or_q),
    .match_o      (match)
  );

  // Capture the configuration on every accepted arm.
  always_ff @(posedge clk_PLL or negedge reset_n) begin
    if (!reset_n) begin
      edge_mask_q  <= '0;
      edge_rise_q  <= '0;
      level_mask_q <= '0;
      level_val_q  <= '0;
      mode_or_q    <= 1'b0;
    end else if (cfg_load) begin
      edge_mask_q  <= edge_mask;
      edge_rise_q  <= edge_rise;
      level_mask_q <= level_mask;
      level_val_q  <= level_val;
      mode_or_q    <= mode_or;
    end
  end

`ifdef TRIGGER_ENGINE_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] match_count_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_target;

  // Saturating increment; a zero request behaves like a request for one.
  always_comb begin
    cnt_d      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;
    cnt_target = (match_count_q == '0) ? CNT_ONE : match_count_q;
  end

  assign count_done = (cnt_d >= cnt_target);

  // Occurrence counter: cleared on arm/abort, bumped on each match.
  always_ff @(posedge clk_PLL or negedge reset_n) begin
    if (!reset_n) begin
      match_count_q <= '0;
      cnt_q         <= '0;
    end else begin
      if (cfg_load) begin
        match_count_q <= match_count;
      end
      if (cfg_load || abort) begin
        cnt_q <= '0;
      end else if (eval_hit) begin
        cnt_q <= cnt_d;
      end
    end
  end
`else
  // Without the counter the first match fires; match_count is left dangling.
  logic match_count_unused;
  assign match_count_unused = ^match_count;
  assign count_done         = 1'b1;
`endif

  // FSM next state and trigger pulse generation.
  always_comb begin
    state_d = state_q;
    trig_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else if (arm) begin
      state_d = PRIME;
    end else if (sample_en) begin
      if (state_q == PRIME) begin
        state_d = ARMED;
      end else if (eval_hit && count_done) begin
        state_d = TRIGGERED;
        trig_d  = 1'b1;
      end
    end
  end

  // Sample register, valid strobe, trigger pulse and FSM state.
  always_ff @(posedge clk_PLL or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      trig_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      if (sample_en) begin
        data_q <= sync_out;
      end
      valid_q <= sample_en;
      trig_q  <= trig_d;
      state_q <= state_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign trig_pulse = trig_q;
  assign armed      = (state_q == PRIME) || (state_q == ARMED);
  assign triggered  = (state_q == TRIGGERED);

endmodule

// File: tb/tb_trigger_engine.sv
// Scoreboard bench for trigger_engine: each issued sample pushes its
// expected output record; a monitor pops and compares on every data_valid.
module tb_trigger_engine;

  localparam int CH = 8;
  localparam int SS = 2;
  localparam int CW = 8;
`ifdef TRIGGER_ENGINE_COUNT_EN
  localparam int EXP_EDGE = 3;
`else
  localparam int EXP_EDGE = 1;
`endif

  logic          clk;
  logic          reset_n;
  logic          sample_en;
  logic [CH-1:0] data_in;
  logic          arm;
  logic          abort;
  logic [CH-1:0] edge_mask;
  logic [CH-1:0] edge_rise;
  logic [CH-1:0] level_mask;
  logic [CH-1:0] level_val;
  logic          mode_or;
  logic [CW-1:0] match_count;
  logic [CH-1:0] data_out;
  logic          data_valid;
  logic          armed;
  logic          trig_pulse;
  logic          triggered;

  trigger_engine #(
    .CHANNELS    (CH),
    .SYNC_STAGES (SS),
    .CNT_W       (CW)
  ) dut (
    .clk_PLL     (clk),
    .reset_n     (reset_n),
    .sample_en   (sample_en),
    .data_in     (data_in),
    .arm         (arm),
    .abort       (abort),
    .edge_mask   (edge_mask),
    .edge_rise   (edge_rise),
    .level_mask  (level_mask),
    .level_val   (level_val),
    .mode_or     (mode_or),
    .match_count (match_count),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .armed       (armed),
    .trig_pulse  (trig_pulse),
    .triggered   (triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] data;
    logic          trig;
    logic          trg;
    logic          arm;
  } exp_t;

  exp_t q[$];
  int checks  = 0;
  int errors  = 0;
  int n_sent  = 0;
  int n_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one record per data_valid strobe.
  always @(negedge clk) begin
    if (reset_n && data_valid) begin
      n_valid++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data_out=%02h expected no sample", data_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("sample %0d data_out=%02h trig=%0b triggered=%0b armed=%0b (exp %02h %0b %0b %0b)",
                 n_valid, data_out, trig_pulse, triggered, armed, e.data, e.trig, e.trg, e.arm);
        chk("data_out", 32'(data_out), 32'(e.data));
        chk("trig_pulse", 32'(trig_pulse), 32'(e.trig));
        chk("triggered", 32'(triggered), 32'(e.trg));
        chk("armed", 32'(armed), 32'(e.arm));
      end
    end
  end

  // Present a value long enough to clear the synchroniser, then sample it.
  task automatic send(input logic [CH-1:0] d, input logic et, input logic etg, input logic ea);
    exp_t e;
    @(posedge clk);
    #1 data_in = d;
    repeat (SS) @(posedge clk);
    #1 sample_en = 1'b1;
    e.data = d; e.trig = et; e.trg = etg; e.arm = ea;
    q.push_back(e);
    n_sent++;
    @(posedge clk);
    #1 sample_en = 1'b0;
  endtask

  // Arm, then scramble the config inputs so only the latched copy is valid.
  task automatic do_arm(input logic [CH-1:0] em, input logic [CH-1:0] er, input logic [CH-1:0] lm,
                        input logic [CH-1:0] lv, input logic mo, input logic [CW-1:0] mc);
    @(posedge clk);
    #1 edge_mask = em; edge_rise = er; level_mask = lm; level_val = lv;
    mode_or = mo; match_count = mc; arm = 1'b1;
    @(posedge clk);
    #1 arm = 1'b0;
    edge_mask = ~em; edge_rise = ~er; level_mask = ~lm; level_val = ~lv;
    mode_or = ~mo; match_count = 8'd1;
    chk("armed_after_arm", 32'(armed), 32'd1);
    chk("triggered_after_arm", 32'(triggered), 32'd0);
  endtask

  task automatic do_abort(input logic with_arm);
    @(posedge clk);
    #1 abort = 1'b1; arm = with_arm;
    @(posedge clk);
    #1 abort = 1'b0; arm = 1'b0;
    chk("armed_after_abort", 32'(armed), 32'd0);
    chk("triggered_after_abort", 32'(triggered), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; sample_en = 1'b1; data_in = 8'hAA; arm = 1'b0; abort = 1'b0;
    edge_mask = '0; edge_rise = '0; level_mask = '0; level_val = '0;
    mode_or = 1'b0; match_count = '0;
    repeat (4) @(posedge clk);
    #1 sample_en = 1'b0; data_in = 8'h00;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_trig_pulse", 32'(trig_pulse), 32'd0);
    chk("rst_triggered", 32'(triggered), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Idle pass-through, then single rising edge on ch0 at the 3rd sample.
    send(8'h00, 0, 0, 0);
    send(8'h3C, 0, 0, 0);
    do_arm(8'h01, 8'h01, 8'h00, 8'h00, 1'b0, 8'd1);
    send(8'h00, 0, 0, 1);
    send(8'h00, 0, 0, 1);
    send(8'h01, 1, 1, 0);
    send(8'h00, 0, 1, 0);

    // Re-arm from TRIGGERED: AND of ch0 rising with level on ch3:2 == 2'b10.
    do_arm(8'h01, 8'h01, 8'h0C, 8'h08, 1'b0, 8'd1);
    send(8'h00, 0, 0, 1);
    send(8'h08, 0, 0, 1);
    send(8'h0D, 0, 0, 1);
    send(8'h0C, 0, 0, 1);
    send(8'h0D, 0, 0, 1);
    send(8'h08, 0, 0, 1);
    send(8'h09, 1, 1, 0);

    // Occurrence count: rising edge on ch1 every 4 samples, match_count = 3.
    do_abort(1'b0);
    do_arm(8'h02, 8'h02, 8'h00, 8'h00, 1'b0, 8'd3);
    send(8'h00, 0, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      send(8'h02, logic'(k == EXP_EDGE), logic'(k >= EXP_EDGE), logic'(k < EXP_EDGE));
      for (int j = 0; j < 3; j++) send(8'h00, 0, logic'(k >= EXP_EDGE), logic'(k < EXP_EDGE));
    end

    // PRIME must not evaluate: 00 -> FF across arm would be a false rise.
    do_abort(1'b0);
    send(8'h00, 0, 0, 0);
    do_arm(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 8'd1);
    send(8'hFF, 0, 0, 1);
    send(8'hFF, 0, 0, 1);
    send(8'hFF, 0, 0, 1);
    do_abort(1'b0);

    // Falling edge on any channel, input held high at arm, then FE.
    do_arm(8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 8'd1);
    send(8'hFF, 0, 0, 1);
    send(8'hFF, 0, 0, 1);
    send(8'hFF, 0, 0, 1);
    send(8'hFE, 1, 1, 0);

    // arm and abort in the same cycle while ARMED: abort wins.
    do_abort(1'b0);
    do_arm(8'h01, 8'h01, 8'h00, 8'h00, 1'b0, 8'd1);
    send(8'h00, 0, 0, 1);
    send(8'h00, 0, 0, 1);
    do_abort(1'b1);
    send(8'h01, 0, 0, 0);

    // No condition enabled: first ARMED sample triggers (match_count 0 acts as 1).
    do_arm(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0);
    send(8'h05, 0, 0, 1);
    send(8'h06, 1, 1, 0);

    // Asynchronous reset mid-ARMED clears everything without a clock edge.
    do_arm(8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 8'd1);
    send(8'h0F, 0, 0, 1);
    send(8'h0E, 0, 0, 1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_data_out", 32'(data_out), 32'd0);
    chk("mid_rst_data_valid", 32'(data_valid), 32'd0);
    chk("mid_rst_armed", 32'(armed), 32'd0);
    chk("mid_rst_trig_pulse", 32'(trig_pulse), 32'd0);
    chk("mid_rst_triggered", 32'(triggered), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    send(8'h11, 0, 0, 0);

    repeat (5) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("valid_count", 32'(n_valid), 32'(n_sent));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_engine.md
# trigger_engine

Parametrised multi-channel trigger engine for the logic analyzer capture path: it sits between the input pins (via clk_PLL-domain sampling) and the sample memory writer. Each armed acquisition evaluates per-channel edge and level conditions, combined by AND or OR, and fires once after a programmable number of matches. Sample data passes through with a valid strobe, and the trigger pulse is aligned to the sample that caused it.

## Interface
- CHANNELS, 8: number of probe channels (1..32)
- SYNC_STAGES, 2: input synchroniser flops on data_in (0..3; 0 = inputs already synchronous)
- CNT_W, 8: width of the occurrence counter and match_count
- clk_PLL  in  1  sampling clock
- reset_n  in  1  asynchronous, active-low reset
- sample_en  in  1  sample strobe (decimation tick); 1 = take a sample this cycle
- data_in  in  CHANNELS  raw probe inputs
- arm  in  1  single-cycle pulse: latch config, start acquisition
- abort  in  1  single-cycle pulse: return to IDLE
- edge_mask  in  CHANNELS  1 = edge condition enabled on channel
- edge_rise  in  CHANNELS  1 = rising edge, 0 = falling edge
- level_mask  in  CHANNELS  1 = level condition enabled on channel
- level_val  in  CHANNELS  required level per channel
- mode_or  in  1  0 = AND all enabled conditions, 1 = OR
- match_count  in  CNT_W  matches required before trigger (0 treated as 1)
- data_out  out  CHANNELS  current registered sample
- data_valid  out  1  one-cycle strobe per sample on data_out
- armed  out  1  high in PRIME and ARMED
- trig_pulse  out  1  one-cycle pulse coincident with data_valid of triggering sample
- triggered  out  1  high from trig_pulse until next arm/abort

## Operation
- FSM states: IDLE, PRIME, ARMED, TRIGGERED.
- IDLE: samples still flow to data_out/data_valid; no evaluation. arm -> PRIME.
- On arm: edge_mask, edge_rise, level_mask, level_val, mode_or, match_count latched into config registers; occurrence counter cleared. Later changes to config inputs are ignored until the next arm.
- PRIME: first sample after arm captured as prev; no evaluation (prevents false edge). -> ARMED on that sample.
- ARMED, per sample: rise_i = !prev_i & new_i; fall_i = prev_i & !new_i; edge_hit_i = edge_rise_i ? rise_i : fall_i; lvl_hit_i = (new_i == level_val_i).
- Channel condition c_i: enabled terms ANDed within the channel (edge and level both set => both required); channel with no term enabled is excluded.
- AND mode: match = all included channels true. OR mode: match = any included channel true.
- No term enabled on any channel: match on the first ARMED sample (immediate trigger).
- Each match increments the occurrence counter; when counter reaches max(match_count,1): trig_pulse, -> TRIGGERED. Counter saturates, never wraps.
- TRIGGERED: no further evaluation; data continues to pass. arm -> PRIME (re-arm); abort -> IDLE.
- abort has priority over arm in the same cycle; abort in any state -> IDLE, triggered cleared.
- arm while already PRIME/ARMED: restarts (re-latches config, clears counter, -> PRIME).

## Timing
- Reset (reset_n low, asynchronous): state IDLE, all outputs 0, sync/prev/new registers 0, counter 0.
- Pipeline: data_in -> SYNC_STAGES flops -> new register (loaded on sample_en) -> data_out.
- data_valid asserts the cycle after sample_en; latency data_in to data_out = SYNC_STAGES + 1 cycles.
- trig_pulse asserts in the same cycle as data_valid of the sample that completed the count; triggered rises that cycle.
- armed rises the cycle after arm; falls in the cycle trig_pulse asserts, or the cycle after abort.
- sample_en low: all registers hold; no evaluation.
- sample_en continuously high: one evaluation per clk_PLL cycle, full rate.

## Configuration
- TRIGGER_ENGINE_COUNT_EN defined: occurrence counter and match_count in effect as above.
- Not defined: counter logic removed, match_count ignored (port kept, unconnected); trigger fires on first match.

## Structure
- Shared package trigger_pkg: state enum (IDLE, PRIME, ARMED, TRIGGERED), state width constant, default CHANNELS/CNT_W constants.
- One sub-module: trigger_cond_eval (combinational per-sample match from prev, new and latched config; parametrised by CHANNELS).

## Test plan
- CHANNELS=8, edge_mask=8'h01, edge_rise=1, arm; drive ch0 0->1 on 3rd sample -> single trig_pulse with data_out=8'h01, triggered=1, armed=0.
- AND mode, level_mask=8'h0C, level_val=8'h08, edge_mask=8'h01 rising; 8'h08 then 8'h09 -> trigger on 8'h09 only; 8'h0D never triggers.
- match_count=3, edge on ch1 each 4 samples -> trig_pulse on 3rd edge; with TRIGGER_ENGINE_COUNT_EN undefined -> on 1st edge.
- data_in held at 8'hFF at arm, edge_mask=8'hFF falling, no change -> no trigger (PRIME suppresses false edge); then 8'hFE -> trigger.
- arm and abort same cycle while ARMED -> IDLE, armed=0, triggered=0; reset_n low mid-ARMED -> all outputs 0 immediately, state IDLE.
- sample_en every 4th cycle, config inputs changed after arm -> evaluation uses latched config; data_valid exactly one cycle per sample_en.
